// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the 8N1 UART controller.
//            Holds the TX/RX state encodings, the frame data width, the
//            default timing parameters and the baud divisor helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_CLK_FREQ   = 100_000_000;
  localparam int DEFAULT_BAUD_RATE  = 9600;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Literal names carry a TX_/RX_ prefix so both enums can share one scope.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // Rounded clock divisor producing one oversample tick.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_controller_if
// Purpose  : Bundles the user-side and pin-side signals of the UART.
// Signals  : tx_enable (transmit request level), data_in (byte to send),
//            data_out (last good received byte), tx (serial out), rx (serial in)
// Modports : master - board/user side driving requests and the rx line
//            slave  - the UART controller itself
// Revision : 1.0 - initial release
// ============================================================================
interface uart_controller_if;
  import uart_pkg::*;

  logic                 tx_enable;
  logic [DATA_BITS-1:0] data_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 tx;
  logic                 rx;

  modport master (output tx_enable, data_in, rx, input data_out, tx);
  modport slave  (input tx_enable, data_in, rx, output data_out, tx);
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Free-running divider emitting a one-clk tick every DIV clocks,
//            i.e. OVERSAMPLE ticks per bit period. DIV must be >= 2.
// Ports    : clk    - system clock
//            reset  - asynchronous active-low reset
//            tick_o - one-clk pulse on counter wrap
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_controller
// Purpose  : Full-duplex 8N1 UART. A rising edge on tx_enable sends one frame
//            of data_in on tx; frames on rx update data_out when the stop bit
//            is valid. TX and RX run independently off a shared tick.
// Ports    : clk   - system clock (rising edge)
//            reset - asynchronous active-low reset
//            bus   - uart_controller_if.slave (tx_enable, data_in, data_out,
//                    tx, rx)
// Revision : 1.0 - initial release
// ============================================================================
module uart_controller
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic              clk,
  input  logic              reset,
  uart_controller_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic baud_tick;

  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .tick_o (baud_tick)
  );

  // ---------------------------------------------------------------- sync ---
  // Synchronizers and the edge-detect history reset to 1 so a tx_enable held
  // high across reset does not launch a frame on release.
  logic [1:0] en_sync_q;
  logic       en_prev_q;
  logic [1:0] rx_sync_q;
  logic       start_pulse;
  logic       rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_sync_q <= 2'b11;
      en_prev_q <= 1'b1;
      rx_sync_q <= 2'b11;
    end else begin
      en_sync_q <= {en_sync_q[0], bus.tx_enable};
      en_prev_q <= en_sync_q[1];
      rx_sync_q <= {rx_sync_q[0], bus.rx};
    end
  end

  assign start_pulse = en_sync_q[1] & ~en_prev_q;
  assign rx_s        = rx_sync_q[1];

  // ------------------------------------------------------------------ TX ---
  tx_state_t            tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [BW-1:0]        tx_bit_q,   tx_bit_d;
  logic [TW-1:0]        tx_tick_q,  tx_tick_d;
  logic                 tx_wait_q,  tx_wait_d;
  logic                 tx_q,       tx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_tick_q  <= '0;
      tx_wait_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_tick_q  <= tx_tick_d;
      tx_wait_q  <= tx_wait_d;
      tx_q       <= tx_d;
    end
  end

  // tx_wait_q holds the line high in START until the first tick boundary so
  // every bit, including the start bit, spans exactly OVERSAMPLE ticks.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_tick_d  = tx_tick_q;
    tx_wait_d  = tx_wait_q;
    tx_d       = tx_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (start_pulse) begin
          tx_shift_d = bus.data_in;
          tx_bit_d   = '0;
          tx_tick_d  = '0;
          tx_wait_d  = 1'b1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_tick) begin
          if (tx_wait_q) begin
            tx_wait_d = 1'b0;
            tx_d      = 1'b0;
            tx_tick_d = '0;
          end else if (tx_tick_q == OS_LAST) begin
            tx_tick_d  = '0;
            tx_d       = tx_shift_q[0];
            tx_state_d = TX_DATA;
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      TX_DATA: begin
        if (baud_tick) begin
          if (tx_tick_q == OS_LAST) begin
            tx_tick_d = '0;
            if (tx_bit_q == BIT_LAST) begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end else begin
              tx_shift_d = tx_shift_q >> 1;
              tx_d       = tx_shift_q[1];
              tx_bit_d   = tx_bit_q + 1'b1;
            end
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (tx_tick_q == OS_LAST) begin
            tx_tick_d  = '0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_tick_d = tx_tick_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ RX ---
  rx_state_t            rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [BW-1:0]        rx_bit_q,   rx_bit_d;
  logic [TW-1:0]        rx_tick_q,  rx_tick_d;
  logic                 rx_err_q,   rx_err_d;
  logic [DATA_BITS-1:0] dout_q,     dout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
      rx_tick_q  <= '0;
      rx_err_q   <= 1'b0;
      dout_q     <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
      rx_tick_q  <= rx_tick_d;
      rx_err_q   <= rx_err_d;
      dout_q     <= dout_d;
    end
  end

  // rx_err_q blocks new start detection after a bad stop bit until the line
  // has been seen idle-high, so a stuck-low line cannot retrigger frames.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_tick_d  = rx_tick_q;
    rx_err_d   = rx_err_q;
    dout_d     = dout_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_err_q) begin
          if (rx_s) rx_err_d = 1'b0;
        end else if (!rx_s) begin
          rx_tick_d  = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (baud_tick) begin
          if (rx_tick_q == HALF_LAST) begin
            rx_tick_d = '0;
            if (rx_s) begin
              rx_state_d = RX_IDLE;
            end else begin
              rx_bit_d   = '0;
              rx_state_d = RX_DATA;
            end
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (baud_tick) begin
          if (rx_tick_q == OS_LAST) begin
            rx_tick_d  = '0;
            rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == BIT_LAST) begin
              rx_state_d = RX_STOP;
            end else begin
              rx_bit_d = rx_bit_q + 1'b1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
        end
      end
      RX_STOP: begin
        if (baud_tick) begin
          if (rx_tick_q == OS_LAST) begin
            rx_tick_d  = '0;
            rx_state_d = RX_IDLE;
            if (rx_s) begin
              dout_d = rx_shift_q;
            end else begin
              rx_err_d = 1'b1;
            end
          end else begin
            rx_tick_d = rx_tick_q + 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign bus.tx       = tx_q;
  assign bus.data_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_controller
// Purpose  : Self-checking bench for uart_controller with DIV=4 (64 clk/bit).
//            Expected bytes are queued when a transmit is requested and
//            compared against the frame seen on tx and against data_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_controller;
  import uart_pkg::*;

  localparam int BIT_CLK   = 64;
  localparam int FRAME_CLK = 10 * BIT_CLK;

  logic clk = 1'b0;
  logic reset;
  logic loopback;
  logic rx_drv;

  always #5 clk = ~clk;

  uart_controller_if bus();

  assign bus.rx = loopback ? bus.tx : rx_drv;

  uart_controller #(
    .CLK_FREQ   (640_000),
    .BAUD_RATE  (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    exp_q.push_back(b);
    bus.data_in   = b;
    bus.tx_enable = 1'b1;
  endtask

  // Waits for the start bit, traces every clk of the frame against the
  // queued byte, then checks data_out once the frame has looped back.
  task automatic check_frame(input string tag);
    int         waited = 0;
    int         bad    = 0;
    logic [7:0] exp_b;
    logic [9:0] exp_f;
    logic [9:0] got_f  = '0;
    while (bus.tx !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_start"}, 32'(bus.tx === 1'b0), 32'd1);
    if (bus.tx !== 1'b0) return;
    check({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() == 0) return;
    exp_b = exp_q.pop_front();
    exp_f = {1'b1, exp_b, 1'b0};
    for (int k = 0; k < FRAME_CLK; k++) begin
      if (bus.tx !== exp_f[k / BIT_CLK]) bad++;
      if (k % BIT_CLK == BIT_CLK / 2) got_f[k / BIT_CLK] = bus.tx;
      @(negedge clk);
    end
    check({tag, "_bits"}, 32'(got_f), 32'(exp_f));
    check({tag, "_width"}, 32'(bad), 32'd0);
    check({tag, "_dout"}, 32'(bus.data_out), 32'(exp_b));
  endtask

  task automatic check_idle(input string tag, input int n);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) lows++;
    end
    check(tag, 32'(lows), 32'd0);
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    tick(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      tick(BIT_CLK);
    end
    rx_drv = stop;
    tick(BIT_CLK);
  endtask

  initial begin
    int waited;
    reset         = 1'b0;
    bus.tx_enable = 1'b0;
    bus.data_in   = 8'h00;
    loopback      = 1'b1;
    rx_drv        = 1'b1;
    tick(2);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_dout", 32'(bus.data_out), 32'h00);
    reset = 1'b1;
    check_idle("idle_no_enable", 200);
    check("idle_dout", 32'(bus.data_out), 32'h00);

    // Level held high: one frame only.
    send(8'h91);
    check_frame("f91");
    check_idle("f91_single", 800);
    bus.tx_enable = 1'b0;
    tick(10);

    // Extra rising edges during a frame are dropped.
    send(8'h3C);
    fork
      begin
        tick(25);  bus.tx_enable = 1'b0;
        tick(100); bus.tx_enable = 1'b1;
        tick(25);  bus.tx_enable = 1'b0;
        tick(25);  bus.tx_enable = 1'b1;
        tick(25);  bus.tx_enable = 1'b0;
      end
      check_frame("f3C");
    join
    check_idle("pulse_ignored", 700);

    send(8'hFF);
    check_frame("fFF");
    bus.tx_enable = 1'b0;
    tick(10);
    send(8'hF4);
    check_frame("fF4");
    bus.tx_enable = 1'b0;
    tick(10);

    // data_in changes after the latch.
    send(8'h5A);
    fork
      begin tick(BIT_CLK + 3); bus.data_in = 8'h00; end
      check_frame("f5A");
    join
    bus.tx_enable = 1'b0;
    tick(10);

    // Reset in the middle of data bit 3 (a 0 bit of 8'hC3).
    bus.data_in   = 8'hC3;
    bus.tx_enable = 1'b1;
    waited = 0;
    while (bus.tx !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("rstmid_started", 32'(bus.tx === 1'b0), 32'd1);
    tick(4 * BIT_CLK + BIT_CLK / 2);
    check("rstmid_pre_tx", 32'(bus.tx), 32'd0);
    reset = 1'b0;
    #1;
    check("rstmid_tx", 32'(bus.tx), 32'd1);
    check("rstmid_dout", 32'(bus.data_out), 32'h00);
    check("rstmid_txfsm", 32'(dut.tx_state_q), 32'(TX_IDLE));
    check("rstmid_rxfsm", 32'(dut.rx_state_q), 32'(RX_IDLE));
    bus.tx_enable = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(5);
    send(8'hA5);
    check_frame("fA5");
    bus.tx_enable = 1'b0;
    tick(10);

    // Bench drives rx directly.
    loopback = 1'b0;
    rx_drv   = 1'b1;
    tick(5);
    drive_rx(8'h3C, 1'b0);
    tick(200);
    rx_drv = 1'b1;
    tick(100);
    check("frame_err_dout", 32'(bus.data_out), 32'hA5);
    rx_drv = 1'b0;
    tick(20);
    rx_drv = 1'b1;
    tick(700);
    check("glitch_dout", 32'(bus.data_out), 32'hA5);
    check("glitch_rxfsm", 32'(dut.rx_state_q), 32'(RX_IDLE));
    drive_rx(8'h66, 1'b1);
    rx_drv = 1'b1;
    tick(100);
    check("rx_66_dout", 32'(bus.data_out), 32'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
